// File: rtl/sys_defs.sv
// rtl/sys_defs.sv - shared ALU function encoding and width constants
package sys_defs;

    localparam int SYS_XLEN  = 32;
    localparam int SYS_TAG_W = 6;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } ALU_FUNC;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational integer ALU datapath
module alu_core
    import sys_defs::*;
#(
    parameter int XLEN = SYS_XLEN
) (
    input  logic [XLEN-1:0] opa,
    input  logic [XLEN-1:0] opb,
    input  ALU_FUNC         func,
    output logic [XLEN-1:0] result
);

    localparam int SH_W = $clog2(XLEN);

    logic [SH_W-1:0] shamt;

    assign shamt = opb[SH_W-1:0];

    always_comb begin
        result = '0;
        unique case (func)
            ALU_ADD:  result = opa + opb;
            ALU_SUB:  result = opa - opb;
            ALU_AND:  result = opa & opb;
            ALU_OR:   result = opa | opb;
            ALU_XOR:  result = opa ^ opb;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(opa) < $signed(opb))};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, (opa < opb)};
            ALU_SLL:  result = opa << shamt;
            ALU_SRL:  result = opa >> shamt;
            ALU_SRA:  result = $unsigned($signed(opa) >>> shamt);
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/fu_alu_pipe.sv
// rtl/fu_alu_pipe.sv - ALU functional unit: reservation buffer, CDB wakeup, result pipeline
// Optional FU_ALU_PIPE_STATS_EN adds saturating issue/stall counters.
module fu_alu_pipe
    import sys_defs::*;
#(
    parameter int XLEN  = SYS_XLEN,
    parameter int DEPTH = 4,
    parameter int TAG_W = SYS_TAG_W,
    parameter int LAT   = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  ALU_FUNC          in_func,
    input  logic [XLEN-1:0]  in_opa,
    input  logic [XLEN-1:0]  in_opb,
    input  logic             in_opa_rdy,
    input  logic             in_opb_rdy,
    input  logic [TAG_W-1:0] in_opa_tag,
    input  logic [TAG_W-1:0] in_opb_tag,
    input  logic [TAG_W-1:0] in_dest_tag,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [XLEN-1:0]  cdb_value,
    input  logic             squash,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TAG_W-1:0] out_tag,
    output logic [XLEN-1:0]  out_result
`ifdef FU_ALU_PIPE_STATS_EN
   ,output logic [31:0]      stat_issued,
    output logic [31:0]      stat_stall
`endif
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0] busy_q, busy_d;
    logic [DEPTH-1:0] opa_rdy_q, opa_rdy_d;
    logic [DEPTH-1:0] opb_rdy_q, opb_rdy_d;
    ALU_FUNC          func_q [DEPTH];
    ALU_FUNC          func_d [DEPTH];
    logic [XLEN-1:0]  opa_q [DEPTH];
    logic [XLEN-1:0]  opa_d [DEPTH];
    logic [XLEN-1:0]  opb_q [DEPTH];
    logic [XLEN-1:0]  opb_d [DEPTH];
    logic [TAG_W-1:0] opa_tag_q [DEPTH];
    logic [TAG_W-1:0] opa_tag_d [DEPTH];
    logic [TAG_W-1:0] opb_tag_q [DEPTH];
    logic [TAG_W-1:0] opb_tag_d [DEPTH];
    logic [TAG_W-1:0] dest_q [DEPTH];
    logic [TAG_W-1:0] dest_d [DEPTH];

    logic [LAT-1:0]   st_valid_q, st_valid_d;
    logic [XLEN-1:0]  st_result_q [LAT];
    logic [XLEN-1:0]  st_result_d [LAT];
    logic [TAG_W-1:0] st_tag_q [LAT];
    logic [TAG_W-1:0] st_tag_d [LAT];

    logic             free_found;
    logic [IDX_W-1:0] alloc_idx;
    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic             accept;
    logic             advance;
    logic             issue_go;
    logic [XLEN-1:0]  alu_result;
    logic             in_opa_hit;
    logic             in_opb_hit;

    // Priority encoders: descending loop leaves the lowest matching index.
    always_comb begin
        free_found = 1'b0;
        alloc_idx  = '0;
        sel_found  = 1'b0;
        sel_idx    = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_found = 1'b1;
                alloc_idx  = IDX_W'(i);
            end
            if (busy_q[i] && opa_rdy_q[i] && opb_rdy_q[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    assign in_ready   = free_found;
    assign accept     = in_valid && free_found;
    assign advance    = !(out_valid && !out_ready);
    assign issue_go   = sel_found && advance && !squash;
    assign in_opa_hit = cdb_valid && (cdb_tag == in_opa_tag);
    assign in_opb_hit = cdb_valid && (cdb_tag == in_opb_tag);

    alu_core #(
        .XLEN(XLEN)
    ) u_alu_core (
        .opa   (opa_q[sel_idx]),
        .opb   (opb_q[sel_idx]),
        .func  (func_q[sel_idx]),
        .result(alu_result)
    );

    always_comb begin
        busy_d    = busy_q;
        opa_rdy_d = opa_rdy_q;
        opb_rdy_d = opb_rdy_q;
        for (int i = 0; i < DEPTH; i++) begin
            func_d[i]    = func_q[i];
            opa_d[i]     = opa_q[i];
            opb_d[i]     = opb_q[i];
            opa_tag_d[i] = opa_tag_q[i];
            opb_tag_d[i] = opb_tag_q[i];
            dest_d[i]    = dest_q[i];

            if (busy_q[i] && !opa_rdy_q[i] && cdb_valid && (cdb_tag == opa_tag_q[i])) begin
                opa_d[i]     = cdb_value;
                opa_rdy_d[i] = 1'b1;
            end
            if (busy_q[i] && !opb_rdy_q[i] && cdb_valid && (cdb_tag == opb_tag_q[i])) begin
                opb_d[i]     = cdb_value;
                opb_rdy_d[i] = 1'b1;
            end
            if (issue_go && (sel_idx == IDX_W'(i))) begin
                busy_d[i] = 1'b0;
            end
            // Allocation only targets a free slot, so it never collides with issue.
            if (accept && (alloc_idx == IDX_W'(i))) begin
                busy_d[i]    = 1'b1;
                func_d[i]    = in_func;
                opa_tag_d[i] = in_opa_tag;
                opb_tag_d[i] = in_opb_tag;
                dest_d[i]    = in_dest_tag;
                opa_rdy_d[i] = in_opa_rdy || in_opa_hit;
                opb_rdy_d[i] = in_opb_rdy || in_opb_hit;
                opa_d[i]     = in_opa_rdy ? in_opa : cdb_value;
                opb_d[i]     = in_opb_rdy ? in_opb : cdb_value;
            end
        end
        if (squash) begin
            busy_d = '0;
        end
    end

    always_comb begin
        st_valid_d = st_valid_q;
        for (int s = 0; s < LAT; s++) begin
            st_result_d[s] = st_result_q[s];
            st_tag_d[s]    = st_tag_q[s];
        end
        if (advance) begin
            st_valid_d[0] = issue_go;
            if (issue_go) begin
                st_result_d[0] = alu_result;
                st_tag_d[0]    = dest_q[sel_idx];
            end
            for (int s = 1; s < LAT; s++) begin
                st_valid_d[s] = st_valid_q[s-1];
                if (st_valid_q[s-1]) begin
                    st_result_d[s] = st_result_q[s-1];
                    st_tag_d[s]    = st_tag_q[s-1];
                end
            end
        end
        if (squash) begin
            st_valid_d = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q     <= '0;
            opa_rdy_q  <= '0;
            opb_rdy_q  <= '0;
            st_valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                func_q[i]    <= ALU_ADD;
                opa_q[i]     <= '0;
                opb_q[i]     <= '0;
                opa_tag_q[i] <= '0;
                opb_tag_q[i] <= '0;
                dest_q[i]    <= '0;
            end
            for (int s = 0; s < LAT; s++) begin
                st_result_q[s] <= '0;
                st_tag_q[s]    <= '0;
            end
        end else begin
            busy_q     <= busy_d;
            opa_rdy_q  <= opa_rdy_d;
            opb_rdy_q  <= opb_rdy_d;
            st_valid_q <= st_valid_d;
            for (int i = 0; i < DEPTH; i++) begin
                func_q[i]    <= func_d[i];
                opa_q[i]     <= opa_d[i];
                opb_q[i]     <= opb_d[i];
                opa_tag_q[i] <= opa_tag_d[i];
                opb_tag_q[i] <= opb_tag_d[i];
                dest_q[i]    <= dest_d[i];
            end
            for (int s = 0; s < LAT; s++) begin
                st_result_q[s] <= st_result_d[s];
                st_tag_q[s]    <= st_tag_d[s];
            end
        end
    end

    assign out_valid  = st_valid_q[LAT-1];
    assign out_tag    = st_tag_q[LAT-1];
    assign out_result = st_result_q[LAT-1];

`ifdef FU_ALU_PIPE_STATS_EN
    logic [31:0] stat_issued_q, stat_issued_d;
    logic [31:0] stat_stall_q, stat_stall_d;

    // Counters survive squash; they only saturate or reset.
    always_comb begin
        stat_issued_d = stat_issued_q;
        stat_stall_d  = stat_stall_q;
        if (issue_go && (stat_issued_q != '1)) begin
            stat_issued_d = stat_issued_q + 32'd1;
        end
        if (!advance && (stat_stall_q != '1)) begin
            stat_stall_d = stat_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_issued_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            stat_issued_q <= stat_issued_d;
            stat_stall_q  <= stat_stall_d;
        end
    end

    assign stat_issued = stat_issued_q;
    assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: doc/fu_alu_pipe.md
# fu_alu_pipe

Parametrised out-of-order ALU functional unit with a DEPTH-entry local reservation buffer, operand wakeup from the common data bus (CDB), a LAT-stage result pipeline, and a valid/ready result port with backpressure. It sits between dispatch and the CDB arbiter. It replaces the single-slot ALU unit: it holds several waiting instructions, issues the lowest-index ready one each cycle, and squashes everything in flight on a branch recovery.

## Interface
- XLEN, 32, operand/result width
- DEPTH, 4, buffer slots (≥2)
- TAG_W, 6, physical tag width
- LAT, 1, result pipeline stages (≥1)
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- in_valid / in_ready  in / out  1  dispatch handshake; transfer when both high
- in_func  in  ALU_FUNC  operation
- in_opa, in_opb  in  XLEN  operand values
- in_opa_rdy, in_opb_rdy  in  1  operand value valid
- in_opa_tag, in_opb_tag  in  TAG_W  producer tags when not ready
- in_dest_tag  in  TAG_W  destination tag
- cdb_valid  in  1  broadcast valid
- cdb_tag  in  TAG_W  broadcast tag
- cdb_value  in  XLEN  broadcast value
- squash  in  1  flush all slots and the pipeline
- out_valid / out_ready  out / in  1  result handshake
- out_tag  out  TAG_W  destination tag of result
- out_result  out  XLEN  result

## Operation
- Slot state: busy, func, opa/opb value+rdy+tag, dest_tag.
- in_ready = any slot not busy (combinational from occupancy). Accept writes the lowest-index free slot.
- Wakeup: a busy slot with operand not rdy and cdb_valid && cdb_tag==operand tag captures cdb_value and sets rdy.
- An incoming instruction whose operand tag matches the same-cycle CDB broadcast captures cdb_value at allocation. Waking a just-allocated operand is mandatory and must not be lost.
- Select: the lowest-index slot with busy && both rdy issues into stage 1 when the pipeline advances. The slot frees on the same edge.
- Functions: ADD, SUB, AND, OR, XOR, SLT (signed), SLTU, SLL, SRL, SRA. Shift amount is opb[$clog2(XLEN)-1:0]. Results wrap modulo 2^XLEN.
- The result is computed combinationally before stage 1, then carried through stages 2..LAT.
- advance = !(out_valid && !out_ready). When advance is low, the whole pipeline holds and no issue occurs; buffer allocation and wakeup continue.
- squash (synchronous): all busy bits, stage valids and out_valid clear at the next edge. Accept and issue in that cycle are discarded.

## Timing
- Reset values: out_valid=0, out_tag=0, out_result=0, all slots free (in_ready=1), stage valids 0.
- Minimum latency: accept at edge E0 with both operands ready, issue at E1, out_valid high after edge E(LAT).
- CDB wakeup at edge E makes the slot eligible for issue at E+1.
- Throughput is one issue per cycle when out_ready stays high.
- Full condition: DEPTH busy gives in_ready=0. Issue and accept in the same cycle with a full buffer are not merged; in_ready still reflects the pre-edge occupancy.
- out_result and out_tag hold stable while out_valid && !out_ready.
- Reset asserted mid-operation clears state immediately, without waiting for a clock edge.

## Configuration
- FU_ALU_PIPE_STATS_EN defined: adds outputs stat_issued (32b, +1 per issue) and stat_stall (32b, +1 per cycle with advance low). Both saturate at all-ones and reset to 0. Squash does not clear them.
- Undefined: the ports and the counters are absent. Functional behaviour is otherwise identical.

## Structure
- ALU_FUNC enum and the shared tag-width constant live in the shared sys_defs package.
- Sub-module alu_core: purely combinational, takes (opa, opb, func) and produces result. The rest (buffer, select, pipeline) stays in fu_alu_pipe.

## Test plan
- Reset, then accept ADD 5+7 with tag 3, LAT=1 → out_valid two cycles after accept, out_result=12, out_tag=3.
- Accept SUB with opa waiting on tag 9, then CDB tag 9 value 20 (opb=4) → result 16 one cycle after the wakeup edge plus LAT.
- Fill all DEPTH slots with non-ready operands → in_ready=0. One CDB wakeup → one issue, then in_ready=1.
- Hold out_ready=0 with two ready instructions → out_valid held, result stable, second not issued. Release → both drain on consecutive cycles.
- Squash with 3 busy slots and a valid output → next cycle out_valid=0, in_ready=1, and no stale result ever appears.
- SRA 0x80000000 by 4 gives 0xF8000000. SLT -1,1 gives 1. SLTU -1,1 gives 0.
